// File: rtl/noc_seq_pkg.sv
// Shared definitions for the traffic-pattern sequencer: pattern codes, FSM states,
// per-PE field widths, the configuration bundle and destination helpers.
package noc_seq_pkg;

  localparam int PE_NUM = 8;
  localparam int SEND_W = 3;
  localparam int RECV_W = 3;
  localparam int RATE_W = 4;
  localparam int DST_W  = 24;
  localparam int MODE_W = 4;

  localparam logic [2:0] PAT_BIT_COMP = 3'd0;
  localparam logic [2:0] PAT_BIT_REV  = 3'd1;
  localparam logic [2:0] PAT_BIT_ROT  = 3'd2;
  localparam logic [2:0] PAT_SHUFFLE  = 3'd3;
  localparam logic [2:0] PAT_TORNADO  = 3'd4;
  localparam logic [2:0] PAT_NEIGHBOR = 3'd5;
  localparam logic [2:0] PAT_HOTSPOT  = 3'd6;
  localparam logic [2:0] PAT_TURN     = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FIN    = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic [PE_NUM-1:0]        dbg;
    logic [PE_NUM*SEND_W-1:0] send;
    logic [PE_NUM*RECV_W-1:0] recv;
    logic [PE_NUM*RATE_W-1:0] rate;
    logic [PE_NUM*DST_W-1:0]  dst;
    logic [PE_NUM*MODE_W-1:0] mode;
  } seq_cfg_t;

  localparam seq_cfg_t CFG_RESET = '{
    dbg:  {PE_NUM{1'b1}},
    send: {(PE_NUM*SEND_W){1'b0}},
    recv: {(PE_NUM*RECV_W){1'b0}},
    rate: {(PE_NUM*RATE_W){1'b0}},
    dst:  {(PE_NUM*DST_W){1'b0}},
    mode: {(PE_NUM*MODE_W){1'b0}}
  };

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  function automatic logic [2:0] rotl3(input logic [2:0] v);
    return {v[1:0], v[2]};
  endfunction

  // Shuffle order {0,2,4,6,1,3,5,7} is itself rotl3(i), so shuffle rotates that order once more.
  function automatic logic [2:0] pattern_dst(input logic [2:0] sel, input logic [2:0] pe);
    case (sel)
      PAT_BIT_COMP: return ~pe;
      PAT_BIT_REV:  return bitrev3(pe);
      PAT_BIT_ROT:  return rotl3(pe);
      PAT_SHUFFLE:  return rotl3(rotl3(pe));
      PAT_TORNADO:  return pe + 3'd3;
      PAT_NEIGHBOR: return pe + 3'd1;
      PAT_HOTSPOT:  return 3'd0;
      PAT_TURN:     return 3'd0;
      default:      return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/noc_pattern_seq_if.sv
// Control/config bus between a test controller (master) and the pattern sequencer (slave).
// NOC_SEQ_PE_STAMP_EN adds the per-PE finish-cycle stamp bus.
interface noc_pattern_seq_if
  import noc_seq_pkg::*;
#(
  parameter int CNT_W = 16
) ();
  logic                        start;
  logic [2:0]                  pattern_sel;
  logic [PE_NUM-1:0]           pe_enable;
  logic [PE_NUM-1:0]           pe_dbg_mode_wire;
  logic [PE_NUM*SEND_W-1:0]    pe_send_num_wire;
  logic [PE_NUM*RECV_W-1:0]    pe_receive_num_wire;
  logic [PE_NUM*RATE_W-1:0]    pe_rate_wire;
  logic [PE_NUM*DST_W-1:0]     pe_dst_seq_wire;
  logic [PE_NUM*MODE_W-1:0]    pe_mode_wire;
  logic [PE_NUM-1:0]           pe_flush_wire;
  logic [PE_NUM-1:0]           pe_task_receive_finish_flag;
  logic [PE_NUM-1:0]           pe_task_send_finish_flag;
  logic                        busy;
  logic                        done;
  logic                        timeout;
  logic [CNT_W-1:0]            run_cycles;
`ifdef NOC_SEQ_PE_STAMP_EN
  logic [PE_NUM*CNT_W-1:0]     pe_finish_cycle;
`endif

  modport master (
    output start, pattern_sel, pe_task_receive_finish_flag, pe_task_send_finish_flag,
    input  pe_enable, pe_dbg_mode_wire, pe_send_num_wire, pe_receive_num_wire,
           pe_rate_wire, pe_dst_seq_wire, pe_mode_wire, pe_flush_wire,
           busy, done, timeout, run_cycles
`ifdef NOC_SEQ_PE_STAMP_EN
    , input pe_finish_cycle
`endif
  );

  modport slave (
    input  start, pattern_sel, pe_task_receive_finish_flag, pe_task_send_finish_flag,
    output pe_enable, pe_dbg_mode_wire, pe_send_num_wire, pe_receive_num_wire,
           pe_rate_wire, pe_dst_seq_wire, pe_mode_wire, pe_flush_wire,
           busy, done, timeout, run_cycles
`ifdef NOC_SEQ_PE_STAMP_EN
    , output pe_finish_cycle
`endif
  );
endinterface

// File: rtl/noc_pattern_rom.sv
// Combinational pattern table: maps a pattern code to the full per-PE configuration set.
module noc_pattern_rom
  import noc_seq_pkg::*;
(
  input  logic [2:0] pattern_sel,
  output seq_cfg_t   cfg
);

  // Per-PE table lookup; rate stays 0 and debug mode stays on for every pattern.
  always_comb begin
    cfg = CFG_RESET;
    for (int i = 0; i < PE_NUM; i++) begin
      cfg.dst[DST_W*i +: DST_W] = {{(DST_W-3){1'b0}}, pattern_dst(pattern_sel, 3'(i))};
      case (pattern_sel)
        PAT_HOTSPOT: begin
          cfg.send[SEND_W*i +: SEND_W] = (i == 0) ? 3'd0 : 3'd1;
          cfg.recv[RECV_W*i +: RECV_W] = (i == 0) ? 3'd7 : 3'd0;
          cfg.mode[MODE_W*i +: MODE_W] = 4'd1;
        end
        PAT_TURN: begin
          cfg.send[SEND_W*i +: SEND_W] = 3'd7;
          cfg.recv[RECV_W*i +: RECV_W] = 3'd7;
          cfg.mode[MODE_W*i +: MODE_W] = 4'd0;
        end
        default: begin
          cfg.send[SEND_W*i +: SEND_W] = 3'd1;
          cfg.recv[RECV_W*i +: RECV_W] = 3'd1;
          cfg.mode[MODE_W*i +: MODE_W] = 4'd1;
        end
      endcase
    end
  end

endmodule

// File: rtl/noc_pattern_seq.sv
// Traffic-pattern sequencer for the 2x4 mesh: latch pattern, flush, settle, run to finish/timeout.
// Optional NOC_SEQ_PE_STAMP_EN records the RUN cycle at which each PE first reports both finish flags.
module noc_pattern_seq
  import noc_seq_pkg::*;
#(
  parameter int FLUSH_CYC   = 4,
  parameter int SETTLE_CYC  = 50,
  parameter int CNT_W       = 16,   // must match the interface CNT_W
  parameter int TIMEOUT_CYC = 4096
) (
  input logic             clk,
  input logic             rst_n,
  noc_pattern_seq_if.slave bus
);

  localparam int PH_MAX = (FLUSH_CYC > SETTLE_CYC) ? FLUSH_CYC : SETTLE_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]   FLUSH_LAST  = PH_W'(FLUSH_CYC - 1);
  localparam logic [PH_W-1:0]   SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [PE_NUM-1:0] ALL_PE      = {PE_NUM{1'b1}};
  localparam logic [PE_NUM-1:0] NO_PE       = {PE_NUM{1'b0}};

  seq_state_e        state_r;
  logic [PH_W-1:0]   phase_r;
  seq_cfg_t          cfg_r;
  seq_cfg_t          rom_cfg_s;
  logic [PE_NUM-1:0] enable_r;
  logic [PE_NUM-1:0] flush_r;
  logic              busy_r;
  logic              done_r;
  logic              timeout_r;
  logic [CNT_W-1:0]  run_cycles_r;
  logic [CNT_W-1:0]  run_next_s;
  logic [PE_NUM-1:0] pe_fin_s;
  logic              all_fin_s;
  logic              start_acc_s;

  noc_pattern_rom u_rom (
    .pattern_sel (bus.pattern_sel),
    .cfg         (rom_cfg_s)
  );

  assign pe_fin_s    = bus.pe_task_receive_finish_flag & bus.pe_task_send_finish_flag;
  assign all_fin_s   = &pe_fin_s;
  assign start_acc_s = (state_r == ST_IDLE) && bus.start;

  // Saturating increment of the run-cycle counter.
  always_comb begin
    run_next_s = run_cycles_r;
    if (run_cycles_r != {CNT_W{1'b1}}) begin
      run_next_s = run_cycles_r + CNT_W'(1);
    end else begin
      run_next_s = run_cycles_r;
    end
  end

  // Sequencer FSM with all control/status outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      phase_r      <= {PH_W{1'b0}};
      cfg_r        <= CFG_RESET;
      enable_r     <= NO_PE;
      flush_r      <= ALL_PE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      timeout_r    <= 1'b0;
      run_cycles_r <= {CNT_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          enable_r <= NO_PE;
          flush_r  <= ALL_PE;
          if (start_acc_s) begin
            cfg_r        <= rom_cfg_s;
            timeout_r    <= 1'b0;
            run_cycles_r <= {CNT_W{1'b0}};
            phase_r      <= FLUSH_LAST;
            busy_r       <= 1'b1;
            state_r      <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (phase_r == {PH_W{1'b0}}) begin
            flush_r <= NO_PE;
            phase_r <= SETTLE_LAST;
            state_r <= ST_SETTLE;
          end else begin
            phase_r <= phase_r - PH_W'(1);
          end
        end
        ST_SETTLE: begin
          if (phase_r == {PH_W{1'b0}}) begin
            enable_r <= ALL_PE;
            state_r  <= ST_RUN;
          end else begin
            phase_r <= phase_r - PH_W'(1);
          end
        end
        ST_RUN: begin
          run_cycles_r <= run_next_s;
          // Finish takes priority over a timeout landing in the same cycle.
          if (all_fin_s || (run_next_s == TIMEOUT_VAL)) begin
            enable_r  <= NO_PE;
            flush_r   <= ALL_PE;
            done_r    <= 1'b1;
            timeout_r <= ~all_fin_s;
            state_r   <= ST_FIN;
          end
        end
        ST_FIN: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          enable_r <= NO_PE;
          flush_r  <= ALL_PE;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pe_enable           = enable_r;
  assign bus.pe_flush_wire       = flush_r;
  assign bus.pe_dbg_mode_wire    = cfg_r.dbg;
  assign bus.pe_send_num_wire    = cfg_r.send;
  assign bus.pe_receive_num_wire = cfg_r.recv;
  assign bus.pe_rate_wire        = cfg_r.rate;
  assign bus.pe_dst_seq_wire     = cfg_r.dst;
  assign bus.pe_mode_wire        = cfg_r.mode;
  assign bus.busy                = busy_r;
  assign bus.done                = done_r;
  assign bus.timeout             = timeout_r;
  assign bus.run_cycles          = run_cycles_r;

`ifdef NOC_SEQ_PE_STAMP_EN
  logic [PE_NUM-1:0][CNT_W-1:0] stamp_r;

  // A zero field means "not yet finished"; stamps start at 1 since they hold the post-increment count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stamp_r <= {(PE_NUM*CNT_W){1'b0}};
    end else if (start_acc_s) begin
      stamp_r <= {(PE_NUM*CNT_W){1'b0}};
    end else if (state_r == ST_RUN) begin
      for (int i = 0; i < PE_NUM; i++) begin
        if (pe_fin_s[i] && (stamp_r[i] == {CNT_W{1'b0}})) begin
          stamp_r[i] <= run_next_s;
        end
      end
    end
  end

  assign bus.pe_finish_cycle = stamp_r;
`endif

endmodule

// File: tb/tb_noc_pattern_seq.sv
// Scoreboard bench for noc_pattern_seq: randomized patterns and finish-flag traces against a
// reference model of the pattern table and run-length rules.
module tb_noc_pattern_seq;

  localparam int FLUSH_CYC   = 4;
  localparam int SETTLE_CYC  = 50;
  localparam int CNT_W       = 16;
  localparam int TIMEOUT_CYC = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_pattern_seq_if #(.CNT_W(CNT_W)) bus ();

  noc_pattern_seq #(
    .FLUSH_CYC   (FLUSH_CYC),
    .SETTLE_CYC  (SETTLE_CYC),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0]   dbg;
    logic [23:0]  send;
    logic [23:0]  recv;
    logic [31:0]  rate;
    logic [191:0] dst;
    logic [31:0]  mode;
    logic [15:0]  cyc;
    logic         to;
    logic [127:0] stamp;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] flag_seq[$];   // flags per RUN cycle: [7:0] receive, [15:8] send
  logic [15:0] flag_tail;     // flags after flag_seq is exhausted
  int checks = 0;
  int failures = 0;
  int dones = 0;
  int runs = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference pattern table computed from the pattern definitions with plain arithmetic.
  function automatic exp_t model_cfg(input int sel);
    exp_t e;
    int ord[8] = '{0, 2, 4, 6, 1, 3, 5, 7};
    e.dbg = 8'hFF; e.rate = 32'd0; e.send = 24'd0; e.recv = 24'd0;
    e.dst = 192'd0; e.mode = 32'd0; e.cyc = 16'd0; e.to = 1'b0; e.stamp = 128'd0;
    for (int i = 0; i < 8; i++) begin
      int d, s, r, m;
      d = 0; s = 1; r = 1; m = 1;
      case (sel)
        0: d = 7 - i;
        1: d = ((i & 1) << 2) | (i & 2) | (i >> 2);
        2: d = ((i << 1) | (i >> 2)) & 7;
        3: d = ((ord[i] << 1) | (ord[i] >> 2)) & 7;
        4: d = (i + 3) % 8;
        5: d = (i + 1) % 8;
        6: begin s = (i == 0) ? 0 : 1; r = (i == 0) ? 7 : 0; end
        default: begin s = 7; r = 7; m = 0; end
      endcase
      e.send[3*i +: 3] = 3'(s);
      e.recv[3*i +: 3] = 3'(r);
      e.mode[4*i +: 4] = 4'(m);
      e.dst[24*i +: 24] = 24'(d);
    end
    return e;
  endfunction

  // First all-ones RUN cycle gives run_cycles; no such cycle within the budget means timeout.
  function automatic void model_run(inout exp_t e);
    e.cyc = 16'(TIMEOUT_CYC); e.to = 1'b1; e.stamp = 128'd0;
    for (int n = 1; n <= TIMEOUT_CYC; n++) begin
      logic [15:0] v;
      v = (n - 1 < flag_seq.size()) ? flag_seq[n-1] : flag_tail;
      for (int i = 0; i < 8; i++)
        if (e.stamp[16*i +: 16] == 16'd0 && v[i] && v[i+8]) e.stamp[16*i +: 16] = 16'(n);
      if (&v) begin e.cyc = 16'(n); e.to = 1'b0; break; end
    end
  endfunction

  // Random flag trace that first reaches all-ones on RUN cycle fin (tail=all ones).
  task automatic set_flags(input int fin, input logic [15:0] tail);
    flag_seq.delete();
    for (int k = 0; k < fin - 1; k++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if (&v) v[$urandom_range(15, 0)] = 1'b0;
      flag_seq.push_back(v);
    end
    flag_tail = tail;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (bus.busy && n < limit) begin @(negedge clk); n++; end
    if (bus.busy) bound_fail("wait_idle");
  endtask

  task automatic run_pattern(input int sel, input int ignored_sel);
    exp_t e;
    int n;
    e = model_cfg(sel);
    model_run(e);
    sb_q.push_back(e);
    runs++;
    @(negedge clk);
    bus.pattern_sel = 3'(sel);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.pattern_sel = 3'($urandom);
    if (ignored_sel >= 0) begin
      n = 0;
      while (bus.pe_flush_wire != 8'h00 && n < 20) begin @(negedge clk); n++; end
      if (bus.pe_flush_wire != 8'h00) bound_fail("reach_settle");
      repeat (3) @(negedge clk);
      bus.pattern_sel = 3'(ignored_sel);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_idle(TIMEOUT_CYC + 200);
  endtask

  // PE model: presents the prepared flag trace, one entry per cycle with enable high.
  initial begin
    int k;
    logic [15:0] v;
    k = 0;
    bus.pe_task_receive_finish_flag = 8'hFF;
    bus.pe_task_send_finish_flag = 8'hFF;
    forever begin
      @(negedge clk);
      if (bus.pe_enable == 8'hFF) begin
        v = (k < flag_seq.size()) ? flag_seq[k] : flag_tail;
        k++;
      end else begin
        v = 16'hFFFF;
        k = 0;
      end
      bus.pe_task_receive_finish_flag = v[7:0];
      bus.pe_task_send_finish_flag = v[15:8];
    end
  end

  // Monitor: measures phase lengths and checks each done pulse against the scoreboard.
  initial begin
    int fl, st, en;
    logic pd;
    exp_t e;
    fl = 0; st = 0; en = 0; pd = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus.busy) begin fl = 0; st = 0; en = 0; end
      else if (bus.pe_enable == 8'hFF) en++;
      else if (bus.pe_flush_wire == 8'hFF && en == 0 && st == 0) fl++;
      else if (bus.pe_flush_wire == 8'h00 && bus.pe_enable == 8'h00) st++;
      if (bus.done) begin
        dones++;
        chk("done_width", pd, 1'b0);
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got done=1 expected no pending run");
        end else begin
          e = sb_q.pop_front();
          chk("run_cycles", bus.run_cycles, e.cyc);
          chk("timeout", bus.timeout, e.to);
          chk("send", bus.pe_send_num_wire, e.send);
          chk("recv", bus.pe_receive_num_wire, e.recv);
          chk("rate", bus.pe_rate_wire, e.rate);
          chk("dst", bus.pe_dst_seq_wire, e.dst);
          chk("mode", bus.pe_mode_wire, e.mode);
          chk("dbg", bus.pe_dbg_mode_wire, e.dbg);
          chk("flush_len", fl, FLUSH_CYC);
          chk("settle_len", st, SETTLE_CYC);
          chk("run_len", en, e.cyc);
          chk("fin_outputs", {bus.busy, bus.pe_enable, bus.pe_flush_wire}, {1'b1, 8'h00, 8'hFF});
`ifdef NOC_SEQ_PE_STAMP_EN
          chk("finish_stamp", bus.pe_finish_cycle, e.stamp);
`endif
        end
      end
      pd = bus.done;
    end
  end

  initial begin
    int n;
    bus.start = 1'b0;
    bus.pattern_sel = 3'd0;
    flag_tail = 16'hFFFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_enable", bus.pe_enable, 8'h00);
    chk("rst_flush", bus.pe_flush_wire, 8'hFF);
    chk("rst_dbg", bus.pe_dbg_mode_wire, 8'hFF);
    chk("rst_cfg", {bus.pe_send_num_wire, bus.pe_receive_num_wire, bus.pe_rate_wire,
                    bus.pe_mode_wire}, 112'd0);
    chk("rst_dst", bus.pe_dst_seq_wire, 192'd0);
    chk("rst_status", {bus.busy, bus.done, bus.timeout, bus.run_cycles}, 19'd0);

    set_flags(20, 16'hFFFF);
    run_pattern(0, -1);
    chk("p0_dst_pe0", bus.pe_dst_seq_wire[2:0], 3'd7);
    chk("p0_dst_pe7", bus.pe_dst_seq_wire[170:168], 3'd0);

    set_flags(1, 16'hFFFF);
    run_pattern(6, -1);
    chk("p6_send", bus.pe_send_num_wire, 24'o11111110);
    chk("p6_recv", bus.pe_receive_num_wire, 24'o00000007);
    chk("p6_dst", bus.pe_dst_seq_wire, 192'd0);

    for (int r = 0; r < 8; r++) begin
      set_flags($urandom_range(60, 1), 16'hFFFF);
      run_pattern(r, -1);
    end

    set_flags(25, 16'hFFFF);
    run_pattern(2, 7);

    // Staircase finish: PE i raises both flags on RUN cycle 10+i.
    flag_seq.delete();
    for (int k = 0; k < 17; k++) begin
      logic [15:0] v;
      v = 16'd0;
      for (int i = 0; i < 8; i++) if (k + 1 >= 10 + i) begin v[i] = 1'b1; v[i+8] = 1'b1; end
      flag_seq.push_back(v);
    end
    flag_tail = 16'hFFFF;
    run_pattern(4, -1);

    set_flags(1, 16'h0000);
    run_pattern(5, -1);
    repeat (2) @(negedge clk);
    chk("timeout_sticky", bus.timeout, 1'b1);

    set_flags(TIMEOUT_CYC, 16'hFFFF);
    run_pattern(3, -1);

    set_flags(1, 16'h0000);
    @(negedge clk);
    bus.pattern_sel = 3'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.pe_enable != 8'hFF && n < 100) begin @(negedge clk); n++; end
    if (bus.pe_enable != 8'hFF) bound_fail("reach_run");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outputs", {bus.pe_enable, bus.pe_flush_wire, bus.busy, bus.done, bus.timeout},
        {8'h00, 8'hFF, 3'b000});
    chk("arst_counts", {bus.run_cycles, bus.pe_send_num_wire, bus.pe_dbg_mode_wire},
        {16'd0, 24'd0, 8'hFF});
    @(negedge clk);
    rst_n = 1'b1;

    set_flags($urandom_range(40, 1), 16'hFFFF);
    run_pattern(7, -1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    chk("done_count", dones, runs);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
